// File: rtl/dat_serializer_tx.sv
// rtl/dat_serializer_tx.sv - SD DAT line block serializer: start, data MSB-first, CRC16 (DAT_TX_CRC16_EN), end
module dat_serializer_tx #(
  parameter int N               = 32,
  parameter int WORDS_PER_BLOCK = 128
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] parallel_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic         serial_out,
  output logic         serial_oe,
  output logic         busy,
  output logic         complete,
  output logic         underrun
);

  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END} state_t;

  state_t             state, state_d;
  logic [N-1:0]       shift_reg, shift_d, next_word;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [WORD_W-1:0]  word_cnt, word_cnt_d;
  logic               serial_out_d, serial_oe_d, busy_d, complete_d, underrun_d;
  logic               at_boundary, last_word;

  assign at_boundary = (bit_cnt == '0);
  assign last_word   = (word_cnt == WORD_LAST);

`ifdef DAT_TX_CRC16_EN
  logic [15:0] crc, crc_d, crc_next;
  logic [3:0]  crc_cnt, crc_cnt_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // serial_out holds the data bit currently on the line, so it feeds the CRC directly
  assign crc_next = crc_step(crc, serial_out);
`endif

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      serial_out <= 1'b1;
      serial_oe  <= 1'b0;
      busy       <= 1'b0;
      complete   <= 1'b0;
      underrun   <= 1'b0;
`ifdef DAT_TX_CRC16_EN
      crc        <= '0;
      crc_cnt    <= '0;
`endif
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      bit_cnt    <= bit_cnt_d;
      word_cnt   <= word_cnt_d;
      serial_out <= serial_out_d;
      serial_oe  <= serial_oe_d;
      busy       <= busy_d;
      complete   <= complete_d;
      underrun   <= underrun_d;
`ifdef DAT_TX_CRC16_EN
      crc        <= crc_d;
      crc_cnt    <= crc_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (enable && word_valid) state_d = S_START;
      S_START: state_d = S_DATA;
      S_DATA: begin
        if (at_boundary && last_word) begin
`ifdef DAT_TX_CRC16_EN
          state_d = S_CRC;
`else
          state_d = S_END;
`endif
        end
      end
`ifdef DAT_TX_CRC16_EN
      S_CRC:   if (crc_cnt == 4'd0) state_d = S_END;
`endif
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded with the value the line must show in the next state
  always_comb begin
    word_ready   = 1'b0;
    next_word    = '0;
    shift_d      = shift_reg;
    bit_cnt_d    = bit_cnt;
    word_cnt_d   = word_cnt;
    underrun_d   = underrun;
    serial_out_d = 1'b1;
    serial_oe_d  = 1'b0;
    busy_d       = 1'b0;
    complete_d   = 1'b0;
`ifdef DAT_TX_CRC16_EN
    crc_d        = crc;
    crc_cnt_d    = crc_cnt;
`endif
    case (state)
      S_IDLE: begin
        word_ready = enable;
        if (enable && word_valid) begin
          shift_d      = parallel_in;
          bit_cnt_d    = BIT_LAST;
          word_cnt_d   = '0;
          underrun_d   = 1'b0;
          serial_out_d = 1'b0;
          serial_oe_d  = 1'b1;
          busy_d       = 1'b1;
`ifdef DAT_TX_CRC16_EN
          crc_d        = '0;
`endif
        end
      end
      S_START: begin
        serial_out_d = shift_reg[N-1];
        shift_d      = shift_reg << 1;
        bit_cnt_d    = BIT_LAST;
        word_cnt_d   = '0;
        serial_oe_d  = 1'b1;
        busy_d       = 1'b1;
`ifdef DAT_TX_CRC16_EN
        crc_d        = '0;
`endif
      end
      S_DATA: begin
        serial_oe_d = 1'b1;
        busy_d      = 1'b1;
`ifdef DAT_TX_CRC16_EN
        crc_d       = crc_next;
`endif
        if (!at_boundary) begin
          serial_out_d = shift_reg[N-1];
          shift_d      = shift_reg << 1;
          bit_cnt_d    = bit_cnt - 1'b1;
        end else if (!last_word) begin
          // A missing word is replaced by zeros so the block timing never stalls
          word_ready   = 1'b1;
          next_word    = word_valid ? parallel_in : '0;
          underrun_d   = underrun | ~word_valid;
          serial_out_d = next_word[N-1];
          shift_d      = next_word << 1;
          bit_cnt_d    = BIT_LAST;
          word_cnt_d   = word_cnt + 1'b1;
        end else begin
`ifdef DAT_TX_CRC16_EN
          serial_out_d = crc_next[15];
          crc_d        = crc_next << 1;
          crc_cnt_d    = 4'd15;
`else
          serial_out_d = 1'b1;
`endif
        end
      end
`ifdef DAT_TX_CRC16_EN
      S_CRC: begin
        serial_oe_d = 1'b1;
        busy_d      = 1'b1;
        if (crc_cnt != 4'd0) begin
          serial_out_d = crc[15];
          crc_d        = crc << 1;
          crc_cnt_d    = crc_cnt - 1'b1;
        end else begin
          serial_out_d = 1'b1;
        end
      end
`endif
      S_END: begin
        complete_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
